// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard unit: operand-select
// encodings seen by the EX-stage operand muxes and the stall FSM states.
package fwd_pkg;

  // Operand select encodings driven onto fwd_sel for each source
  localparam logic [1:0] FWD_RF  = 2'b00;  // use register-file read value
  localparam logic [1:0] FWD_WB  = 2'b01;  // bypass from the WB stage
  localparam logic [1:0] FWD_MEM = 2'b10;  // bypass from the MEM stage

  // Stall controller states
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_HOLD = 2'b10
  } hazState_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding / hazard unit: ID-stage instruction
// fields and pipeline control in, stall and operand selects out.
interface fwd_hazard_unit_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) ();

  logic                        id_valid;
  logic [REG_AW-1:0]           id_rd;
  logic                        id_regwrite;
  logic                        id_is_load;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic                        flush;
  logic                        mem_busy;
  logic                        stall_id;
  logic [2*NUM_SRC-1:0]        fwd_sel;
  logic [CNT_W-1:0]            stall_cnt;

  // The pipeline drives instruction info and receives stall/forward controls
  modport master (
    output id_valid, id_rd, id_regwrite, id_is_load, id_src, id_src_used,
           flush, mem_busy,
    input  stall_id, fwd_sel, stall_cnt
  );

  // The hazard unit sees the opposite directions
  modport slave (
    input  id_valid, id_rd, id_regwrite, id_is_load, id_src, id_src_used,
           flush, mem_busy,
    output stall_id, fwd_sel, stall_cnt
  );

endinterface

// File: rtl/fwd_src_sel.sv
// Operand select for one EX-stage source: picks the youngest in-flight
// producer of the source register, or the register file when none exists.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              srcUsed,
  input  logic [REG_AW-1:0] srcReg,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] memRd,
  input  logic              wbValid,
  input  logic              wbRegWrite,
  input  logic [REG_AW-1:0] wbRd,
  output logic [1:0]        sel
);

  // MEM is checked before WB so the newer value wins; r0 never forwards
  always_comb begin
    sel = FWD_RF;
    if (srcUsed && (srcReg != '0)) begin
      if (memValid && memRegWrite && (memRd == srcReg)) begin
        sel = FWD_MEM;
      end else if (wbValid && wbRegWrite && (wbRd == srcReg)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for an in-order pipeline. Keeps a
// shadow tag pipeline (EX/MEM/WB) of destination info, detects load-use
// hazards against the ID instruction, and drives per-source bypass selects.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);

  // EX stage tags
  logic                      exValid;
  logic [REG_AW-1:0]         exRd;
  logic                      exRegWrite;
  logic                      exIsLoad;
  logic [NUM_SRC*REG_AW-1:0] exSrc;
  logic [NUM_SRC-1:0]        exSrcUsed;

  // MEM stage tags
  logic                      memValid;
  logic [REG_AW-1:0]         memRd;
  logic                      memRegWrite;
  logic                      memIsLoad;

  // WB stage tags
  logic                      wbValid;
  logic [REG_AW-1:0]         wbRd;
  logic                      wbRegWrite;

  hazState_e                 state;
  logic [NUM_SRC-1:0]        srcMatch;
  logic                      loadUse;
  logic                      hazard;
  logic                      stallId;
  logic [CNT_W-1:0]          stallCnt;
  logic [2*NUM_SRC-1:0]      fwdSel;

  // Which ID sources read the register the EX-stage instruction writes
  always_comb begin
    srcMatch = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      srcMatch[s] = bus.id_src_used[s] &&
                    (bus.id_src[s*REG_AW +: REG_AW] == exRd);
    end
  end

  // A load in EX cannot be bypassed to the ID consumer in time; the stall
  // state already holds a bubble in EX so it never asks for a second one
  assign loadUse = bus.id_valid & exValid & exIsLoad & exRegWrite &
                   (exRd != '0) & (|srcMatch);
  assign hazard  = loadUse & (state != LU_STALL);
  assign stallId = bus.mem_busy | (~bus.flush & hazard);

  // Tag pipeline: freeze on mem_busy, bubble EX on flush or load-use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid     <= 1'b0;
      exRd        <= '0;
      exRegWrite  <= 1'b0;
      exIsLoad    <= 1'b0;
      exSrc       <= '0;
      exSrcUsed   <= '0;
      memValid    <= 1'b0;
      memRd       <= '0;
      memRegWrite <= 1'b0;
      memIsLoad   <= 1'b0;
      wbValid     <= 1'b0;
      wbRd        <= '0;
      wbRegWrite  <= 1'b0;
    end else if (!bus.mem_busy) begin
      wbValid     <= memValid;
      wbRd        <= memRd;
      wbRegWrite  <= memRegWrite;
      memValid    <= exValid;
      memRd       <= exRd;
      memRegWrite <= exRegWrite;
      memIsLoad   <= exIsLoad;
      if (bus.flush || hazard) begin
        exValid    <= 1'b0;
        exRegWrite <= 1'b0;
        exIsLoad   <= 1'b0;
        exSrcUsed  <= '0;
      end else begin
        exValid    <= bus.id_valid;
        exRd       <= bus.id_rd;
        exRegWrite <= bus.id_regwrite;
        exIsLoad   <= bus.id_is_load;
        exSrc      <= bus.id_src;
        exSrcUsed  <= bus.id_valid ? bus.id_src_used : '0;
      end
    end
  end

  // Stall controller: memory freeze overrides everything, load-use lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (bus.mem_busy) begin
      state <= MEM_HOLD;
    end else begin
      case (state)
        RUN:      state <= (hazard && !bus.flush) ? LU_STALL : RUN;
        LU_STALL: state <= RUN;
        MEM_HOLD: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stallId && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : gSrcSel
    fwd_src_sel #(.REG_AW(REG_AW)) uSrcSel (
      .srcUsed     (exSrcUsed[s]),
      .srcReg      (exSrc[s*REG_AW +: REG_AW]),
      .memValid    (memValid),
      .memRegWrite (memRegWrite),
      .memRd       (memRd),
      .wbValid     (wbValid),
      .wbRegWrite  (wbRegWrite),
      .wbRd        (wbRd),
      .sel         (fwdSel[2*s +: 2])
    );
  end

  assign bus.stall_id  = stallId;
  assign bus.fwd_sel   = fwdSel;
  assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed test of fwd_hazard_unit: stimulus pushes hand-computed expected
// outputs for each cycle, a monitor pops and compares at the falling edge.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string      name;
    logic       stall;
    logic [3:0] fwd;
    logic [15:0] cnt;
  } expect_t;

  expect_t sbQ[$];

  fwd_hazard_unit_if #(.REG_AW(4), .NUM_SRC(2), .CNT_W(16)) bus ();

  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of ID inputs just after the rising edge, queue expectation
  task automatic applyStimulus(input string name, input bit rstVal,
                               input bit v, input int rd, input bit rw,
                               input bit ld, input int s0, input int s1,
                               input bit [1:0] used, input bit fl,
                               input bit busy, input bit chk,
                               input bit expStall, input bit [3:0] expFwd,
                               input int expCnt);
    expect_t e;
    @(posedge clk);
    #1;
    rst_n               = rstVal;
    bus.id_valid        = v;
    bus.id_rd           = 4'(rd);
    bus.id_regwrite     = rw;
    bus.id_is_load      = ld;
    bus.id_src          = {4'(s1), 4'(s0)};
    bus.id_src_used     = used;
    bus.flush           = fl;
    bus.mem_busy        = busy;
    if (chk) begin
      e.name  = name;
      e.stall = expStall;
      e.fwd   = expFwd;
      e.cnt   = 16'(expCnt);
      sbQ.push_back(e);
    end
  endtask

  // Compare the DUT outputs against one queued expectation
  task automatic checkOutput(input expect_t e);
    total++;
    if (bus.stall_id !== e.stall || bus.fwd_sel !== e.fwd ||
        bus.stall_cnt !== e.cnt) begin
      bad++;
      $display("[TB] FAIL %s: got stall=%b fwd=%b cnt=%h, want stall=%b fwd=%b cnt=%h",
               e.name, bus.stall_id, bus.fwd_sel, bus.stall_cnt,
               e.stall, e.fwd, e.cnt);
    end
  endtask

  // Monitor: one expectation per checked cycle, sampled at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        checkOutput(sbQ.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n           = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_rd       = '0;
    bus.id_regwrite = 1'b0;
    bus.id_is_load  = 1'b0;
    bus.id_src      = '0;
    bus.id_src_used = '0;
    bus.flush       = 1'b0;
    bus.mem_busy    = 1'b0;

    // reset state
    applyStimulus("reset",      0, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU producer, MEM forward, then WB forward of r3
    applyStimulus("addR3",      1, 1,3,1,0, 1,2, 2'b11, 0,0, 1, 0,4'b0000,0);
    applyStimulus("useR3a",     1, 1,4,1,0, 3,0, 2'b01, 0,0, 1, 0,4'b0000,0);
    applyStimulus("fwdMem",     1, 1,6,1,0, 3,0, 2'b01, 0,0, 1, 0,4'b0010,0);
    applyStimulus("fwdWb",      1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0001,0);

    // two writers of r7: MEM copy beats WB copy on both sources
    applyStimulus("addR7a",     1, 1,7,1,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,0);
    applyStimulus("addR7b",     1, 1,7,1,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,0);
    applyStimulus("useR7",      1, 1,8,1,0, 7,7, 2'b11, 0,0, 1, 0,4'b0000,0);
    applyStimulus("memPrio",    1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b1010,0);

    // load-use on src1: one stall, one bubble, then WB forward
    applyStimulus("loadR5",     1, 1,5,1,1, 0,0, 2'b00, 0,0, 1, 0,4'b0000,0);
    applyStimulus("luStall",    1, 1,9,1,0, 0,5, 2'b10, 0,0, 1, 1,4'b0000,0);
    applyStimulus("luBubble",   1, 1,9,1,0, 0,5, 2'b10, 0,0, 1, 0,4'b0000,1);
    applyStimulus("luFwdWb",    1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0100,1);

    // writes to r0 never forward or stall
    applyStimulus("addR0",      1, 1,0,1,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,1);
    applyStimulus("loadR0",     1, 1,0,1,1, 0,0, 2'b00, 0,0, 1, 0,4'b0000,1);
    applyStimulus("useR0Load",  1, 1,0,1,0, 0,0, 2'b01, 0,0, 1, 0,4'b0000,1);
    applyStimulus("useR0Both",  1, 1,10,1,0, 0,0, 2'b11, 0,0, 1, 0,4'b0000,1);
    applyStimulus("r0NoFwd",    1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,1);

    // load-use coinciding with flush: no stall, count unchanged
    applyStimulus("loadR11",    1, 1,11,1,1, 0,0, 2'b00, 0,0, 1, 0,4'b0000,1);
    applyStimulus("luFlush",    1, 1,12,1,0, 11,0, 2'b01, 1,0, 1, 0,4'b0000,1);
    applyStimulus("postFlush",  1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,1);

    // three-cycle memory freeze holding a MEM forward
    applyStimulus("addR13",     1, 1,13,1,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,1);
    applyStimulus("useR13",     1, 1,14,1,0, 13,13, 2'b11, 0,0, 1, 0,4'b0000,1);
    applyStimulus("busy1",      1, 0,0,0,0, 0,0, 2'b00, 0,1, 1, 1,4'b1010,1);
    applyStimulus("busy2",      1, 0,0,0,0, 0,0, 2'b00, 0,1, 1, 1,4'b1010,2);
    applyStimulus("busy3",      1, 0,0,0,0, 0,0, 2'b00, 0,1, 1, 1,4'b1010,3);
    applyStimulus("busyDone",   1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b1010,4);
    applyStimulus("postBusy",   1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,4);

    // long freeze drives the counter into saturation
    for (int k = 0; k < 65540; k++) begin
      applyStimulus("satCnt", 1, 0,0,0,0, 0,0, 2'b00, 0,1, (k >= 65529),
                    1, 4'b0000, ((4 + k) > 65535) ? 65535 : (4 + k));
    end
    applyStimulus("satHold",    1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,65535);

    // asynchronous reset during LU_STALL discards in-flight load
    applyStimulus("loadR5b",    1, 1,5,1,1, 0,0, 2'b00, 0,0, 1, 0,4'b0000,65535);
    applyStimulus("luStall2",   1, 1,2,1,0, 5,0, 2'b01, 0,0, 1, 1,4'b0000,65535);
    applyStimulus("rstMid",     0, 1,2,1,0, 5,0, 2'b01, 0,0, 1, 0,4'b0000,0);
    applyStimulus("rstRelease", 1, 1,2,1,0, 5,0, 2'b01, 0,0, 1, 0,4'b0000,0);
    applyStimulus("noFwdAfter", 1, 0,0,0,0, 0,0, 2'b00, 0,0, 1, 0,4'b0000,0);

    // let the monitor drain, bounded
    for (int i = 0; i < 5 && sbQ.size() > 0; i++) begin
      @(negedge clk);
    end
    @(posedge clk);
    if (sbQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter REG_AW, 4, register-address width; register 0 is hardwired zero.
REQ-002 Parameter NUM_SRC, 2, source operands per instruction.
REQ-003 Parameter CNT_W, 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_rd  input  REG_AW  ID destination register.
REQ-008 id_regwrite  input  1  ID instruction writes id_rd.
REQ-009 id_is_load  input  1  ID instruction is a load.
REQ-010 id_src  input  NUM_SRC*REG_AW  ID source registers, source s at bits [s*REG_AW +: REG_AW].
REQ-011 id_src_used  input  NUM_SRC  bit s set = source s is read by the instruction.
REQ-012 flush  input  1  taken branch; kill the ID instruction.
REQ-013 mem_busy  input  1  data memory not ready; freeze pipeline.
REQ-014 stall_id  output  1  hold PC and IF/ID register this cycle.
REQ-015 fwd_sel  output  2*NUM_SRC  EX-stage operand select per source, source s at bits [2s+1:2s].
REQ-016 stall_cnt  output  CNT_W  cycles with stall_id=1, saturating.

Function
REQ-017 Internal tag pipeline SHALL hold EX (valid, rd, regwrite, is_load, src, src_used), MEM (valid, rd, regwrite, is_load), WB (valid, rd, regwrite) and advance one stage per cycle when not frozen.
REQ-018 Load-use hazard (combinational) SHALL be id_valid & EX.valid & EX.is_load & EX.regwrite & EX.rd!=0 & (some s: id_src_used[s] & id_src[s]==EX.rd).
REQ-019 Priority SHALL be mem_busy > flush > hazard.
REQ-020 mem_busy=1: all tag stages hold, stall_id=1.
REQ-021 flush=1 (mem_busy=0): EX loads a bubble (valid=0), MEM/WB advance, stall_id=0 even if hazard true.
REQ-022 hazard=1 (no flush/mem_busy): EX loads a bubble, MEM/WB advance, stall_id=1; exactly one bubble per load-use pair.
REQ-023 Otherwise EX loads ID fields with valid=id_valid, stall_id=0.
REQ-024 fwd_sel[s] SHALL be combinational from EX/MEM/WB tags: 2'b00 if !EX.src_used[s] or EX.src[s]==0; else 2'b10 if MEM.valid & MEM.regwrite & MEM.rd==EX.src[s]; else 2'b01 if WB.valid & WB.regwrite & WB.rd==EX.src[s]; else 2'b00.
REQ-025 MEM match takes priority over WB match for the same register (newest value wins).
REQ-026 FSM states RUN, LU_STALL, MEM_HOLD: any state -> MEM_HOLD when mem_busy; MEM_HOLD -> RUN when !mem_busy; RUN -> LU_STALL on hazard; LU_STALL -> RUN after one cycle.
REQ-027 stall_cnt SHALL increment by 1 each cycle stall_id=1 and hold at all-ones.
REQ-028 Invalid or bubble stages SHALL never produce a forward match.

Reset
REQ-029 rst_n low SHALL asynchronously clear all valid bits, state=RUN, stall_cnt=0; hence stall_id=0, fwd_sel=0.
REQ-030 Reset asserted mid-stall or mid-freeze SHALL discard all in-flight tags; first cycle after release behaves as an empty pipeline.

Structure
REQ-031 Package fwd_pkg SHALL hold FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the FSM state enum.
REQ-032 Per-source select logic SHALL be sub-module fwd_src_sel, instantiated NUM_SRC times by generate.
REQ-033 Implementation SHALL be 120-400 lines of RTL.

Verification (REG_AW=4, NUM_SRC=2)
REQ-034 ADD r3 then ADD using r3 as src0 -> consumer in EX: fwd_sel=2'b10 (src0 bits); two cycles later third reader of r3 gets 2'b01.
REQ-035 LOAD r5 then ADD src1=r5 -> one cycle stall_id=1, bubble; consumer in EX gets src1 sel 2'b01; stall_cnt=1.
REQ-036 Writes to r0 by EX/MEM/WB, reader src0=r0 -> fwd_sel=0, no stall.
REQ-037 Load-use hazard and flush same cycle -> stall_id=0, EX bubble, stall_cnt unchanged.
REQ-038 mem_busy for 3 cycles mid-sequence -> stall_id=1 for 3 cycles, fwd_sel constant, tags unchanged; stall_cnt saturates at 16'hFFFF under long busy.
REQ-039 rst_n pulsed low asynchronously during LU_STALL -> outputs zero immediately; no forwards after release.
